exc_arbiter: RTL and testbench
==============================

Name: exc_arbiter

Overview:
- Sits directly upstream of the coprocessor-0 register file.
- Gathers synchronous exception requests from the memory stage, external hardware interrupt lines, the software-interrupt bits and the timer compare match.
- Applies Status masking and fixed priority, then presents one exc_code/exc_ip/exc_epc/exc_badvaddr set to CP0 for exactly one cycle.
- Holds off further requests until CP0 reports the vector jump through exc_jmp_flag, and flushes the pipeline meanwhile.

Parameters:
- NR_HW_IRQ, 6, number of external interrupt lines; maps to Cause.IP[7:2].
- SYNC_STAGES, 2, flip-flop depth of the hw_irq synchroniser; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low: state is cleared on a posedge while rst==0.
- hw_irq  input  NR_HW_IRQ  asynchronous level interrupt lines.
- cp0_status  input  32  current Status register (IE=bit0, EXL=bit1, IM=bits15:8).
- cp0_cause  input  32  current Cause register; bits 9:8 are the software interrupts.
- cp0_count  input  32  current Count register.
- cp0_compare  input  32  current Compare register.
- compare_write  input  1  pulse; the pipeline writes Compare this cycle.
- mem_valid  input  1  memory stage holds a real instruction.
- mem_exc_code  input  EXC_CODE_WIDTH  instruction's exception; EC_NONE, EC_ERET or a MIPS code.
- mem_pc  input  32  PC of the memory-stage instruction.
- mem_in_delay_slot  input  1  instruction sits in a branch delay slot.
- mem_badvaddr  input  32  faulting address for address and TLB faults.
- exc_jmp_flag  input  1  from CP0; asserted one cycle when the vector jump is taken.
- exc_ip  output  INT_MASK_WIDTH  pending-interrupt vector to CP0.
- exc_code  output  EXC_CODE_WIDTH  request to CP0.
- exc_epc  output  32  EPC to CP0.
- exc_badvaddr  output  32  BadVAddr to CP0.
- flush  output  1  squash IF..MEM stages.
- timer_pending  output  1  latched timer interrupt, visible for debug.

Behaviour:
- Reset values: exc_code=EC_NONE; exc_ip, exc_epc, exc_badvaddr = 0; flush=0; timer_pending=0; synchroniser cleared; FSM=IDLE. Reset applied mid-operation returns to IDLE at that edge.
- Synchroniser: hw_irq passes through SYNC_STAGES flops, giving hw_sync. A pulse shorter than one cycle may be lost; this is acceptable.
- Timer: timer_pending is set when cp0_count==cp0_compare and cp0_compare!=0. It is cleared when compare_write==1; a clear in the same cycle as a match wins.
- Pending vector: ip = {timer_pending|hw_sync[5], hw_sync[4:0], cp0_cause[9:8]}, registered into exc_ip every cycle.
- int_req = cp0_status[0] & ~cp0_status[1] & |(ip & cp0_status[15:8]) & mem_valid.
- Priority, IDLE only:
  - int_req first, issued as code 0 (Int).
  - Then mem_exc_code other than EC_NONE, with mem_valid=1, passed through unchanged; EC_ERET is passed through this way as well.
  - Otherwise exc_code stays EC_NONE.
- Dependence on mem_valid: with mem_valid=0 nothing is issued, not even a pending interrupt.
- epc = mem_in_delay_slot ? mem_pc-4 : mem_pc, using 32-bit wrap arithmetic.
- exc_badvaddr is mem_badvaddr for a synchronous exception and 0 for Int.
- FSM IDLE: on any issue, register the outputs. exc_code is non-NONE for exactly the next cycle; flush=1 in that cycle. Move to FIRED.
- FSM FIRED: exc_code returns to EC_NONE and flush stays 1. Go to WAIT when exc_jmp_flag==0; go straight to IDLE when exc_jmp_flag==1 (CP0 responds one posedge after the request).
- FSM WAIT: flush=1 and all requests are ignored. Go to IDLE on exc_jmp_flag==1.
- A request arriving on the same cycle as the return to IDLE is evaluated on the next cycle; at most one issue every 2 cycles.
- EXL=1 masks interrupts but not synchronous exceptions; those still issue, and CP0 handles the nested case.

Optional Feature:
- TIMER_IRQ_EN.
- Defined: timer logic as described; ip[7] = timer_pending | hw_sync[5].
- Undefined: no compare logic; timer_pending is tied to 0 and ip[7] = hw_sync[5]. cp0_count, cp0_compare and compare_write are ignored.

Test Plan:
- Reset: hold rst=0 for 2 cycles with hw_irq=6'h3F -> exc_code=EC_NONE, flush=0, exc_ip=0; after release exc_ip[7:2] reads 6'h3F after SYNC_STAGES+1 cycles.
- Syscall: mem_valid=1, mem_exc_code=8, mem_pc=32'h8000_0100, delay slot=0 -> next cycle exc_code=8, exc_epc=32'h8000_0100, flush=1; then EC_NONE until exc_jmp_flag.
- Delay-slot interrupt with priority: status=32'h0000_0401, hw_irq[0]=1 (IP2), mem_exc_code=12, delay slot=1, mem_pc=32'h8000_0204 -> exc_code=0, exc_epc=32'h8000_0200, exc_ip[2]=1.
- Masking: as the previous case but status.EXL=1 -> exc_code=12, not Int. Status.IM2=0 with no mem exception -> exc_code stays EC_NONE.
- Timer (TIMER_IRQ_EN): compare=5, count steps 4->5 -> timer_pending=1 on the next cycle; with IM7 and IE set, Int is issued. compare_write=1 -> timer_pending=0 on the next cycle.
- Holdoff: a second syscall presented while in WAIT is ignored until exc_jmp_flag pulses; it issues 2 cycles later. Asserting rst=0 while in WAIT returns to IDLE with flush=0.

Source files
------------

// File: rtl/exc_arbiter.sv
// -----------------------------------------------------------------------------
// exc_arbiter
//
// Collects exception sources in front of the CP0 register file and hands CP0
// at most one request at a time:
//   * synchronous exceptions (and ERET) reported by the memory stage,
//   * external hardware interrupt lines (synchronised here),
//   * the two software-interrupt bits of Cause,
//   * the Count/Compare timer match (optional, see below).
// Interrupts are qualified by Status.IE, Status.EXL and Status.IM.
// Interrupts take priority over a memory-stage exception.
// A request is presented as a one-cycle exc_code pulse together with
// exc_epc/exc_badvaddr. The pipeline is flushed from that cycle until CP0
// reports the vector jump on exc_jmp_flag.
//
// Optional feature macro: TIMER_IRQ_EN
//   defined   -> Count==Compare (Compare!=0) latches timer_pending, which is
//                OR-ed into ip[7]; a Compare write clears it.
//   undefined -> no timer logic, timer_pending is 0, and the Count/Compare
//                inputs are ignored.
//
// Ports
//   clk               system clock, all state on posedge
//   rst               synchronous reset, active low
//   hw_irq            asynchronous level interrupt lines -> ip[7:2]
//   cp0_status        Status (IE=0, EXL=1, IM=15:8)
//   cp0_cause         Cause (software interrupts in 9:8)
//   cp0_count         Count
//   cp0_compare       Compare
//   compare_write     Compare is written this cycle
//   mem_valid         memory stage holds a real instruction
//   mem_exc_code      memory-stage exception (EC_NONE / EC_ERET / MIPS code)
//   mem_pc            PC of the memory-stage instruction
//   mem_in_delay_slot instruction sits in a branch delay slot
//   mem_badvaddr      faulting address
//   exc_jmp_flag      CP0 took the vector jump (one-cycle pulse)
//   exc_ip            registered pending-interrupt vector
//   exc_code          one-cycle request code to CP0
//   exc_epc           EPC for the request
//   exc_badvaddr      BadVAddr for the request (0 for interrupts)
//   flush             squash IF..MEM
//   timer_pending     latched timer interrupt
// -----------------------------------------------------------------------------
module exc_arbiter #(
    parameter int NR_HW_IRQ      = 6,
    parameter int SYNC_STAGES    = 2,
    parameter int EXC_CODE_WIDTH = 6,
    parameter int INT_MASK_WIDTH = NR_HW_IRQ + 2,
    parameter logic [EXC_CODE_WIDTH-1:0] EC_NONE = 6'h20,
    parameter logic [EXC_CODE_WIDTH-1:0] EC_ERET = 6'h21
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NR_HW_IRQ-1:0]      hw_irq,
    input  logic [31:0]               cp0_status,
    input  logic [31:0]               cp0_cause,
    input  logic [31:0]               cp0_count,
    input  logic [31:0]               cp0_compare,
    input  logic                      compare_write,
    input  logic                      mem_valid,
    input  logic [EXC_CODE_WIDTH-1:0] mem_exc_code,
    input  logic [31:0]               mem_pc,
    input  logic                      mem_in_delay_slot,
    input  logic [31:0]               mem_badvaddr,
    input  logic                      exc_jmp_flag,
    output logic [INT_MASK_WIDTH-1:0] exc_ip,
    output logic [EXC_CODE_WIDTH-1:0] exc_code,
    output logic [31:0]               exc_epc,
    output logic [31:0]               exc_badvaddr,
    output logic                      flush,
    output logic                      timer_pending
);

    localparam logic [EXC_CODE_WIDTH-1:0] EC_INT = '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRED = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // -------------------------------------------------------------------------
    // hw_irq synchroniser: stage 0 samples the pins, each later stage samples
    // the one before it; the last stage is the usable hw_sync.
    // -------------------------------------------------------------------------
    logic [NR_HW_IRQ-1:0] sync_reg  [SYNC_STAGES];
    logic [NR_HW_IRQ-1:0] sync_next [SYNC_STAGES];
    logic [NR_HW_IRQ-1:0] hw_sync;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = hw_irq;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= '0;
            end
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign hw_sync = sync_reg[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Timer interrupt latch
    // -------------------------------------------------------------------------
    logic timer_pending_int;

`ifdef TIMER_IRQ_EN
    logic timer_pending_reg;
    logic timer_match;

    assign timer_match = (cp0_count == cp0_compare) && (cp0_compare != 32'd0);

    // A Compare write in the same cycle as a match wins: the write re-arms
    // the timer, so the match it coincides with must not be taken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_pending_reg <= 1'b0;
        end else if (compare_write) begin
            timer_pending_reg <= 1'b0;
        end else if (timer_match) begin
            timer_pending_reg <= 1'b1;
        end
    end

    assign timer_pending_int = timer_pending_reg;

    logic unused_bits;
    assign unused_bits = ^{cp0_status, cp0_cause};
`else
    assign timer_pending_int = 1'b0;

    logic unused_bits;
    assign unused_bits = ^{cp0_status, cp0_cause, cp0_count, cp0_compare,
                           compare_write};
`endif

    // -------------------------------------------------------------------------
    // Pending vector and request qualification
    // -------------------------------------------------------------------------
    logic [NR_HW_IRQ-1:0]      hw_bits;
    logic [INT_MASK_WIDTH-1:0] ip;
    logic                      int_req;
    logic                      sync_req;
    logic                      issue;
    logic [31:0]               epc;

    // The timer shares the top hardware line (IP7).
    always_comb begin
        hw_bits              = hw_sync;
        hw_bits[NR_HW_IRQ-1] = hw_sync[NR_HW_IRQ-1] | timer_pending_int;
    end

    assign ip       = {hw_bits, cp0_cause[9:8]};
    assign int_req  = cp0_status[0] & ~cp0_status[1]
                    & (|(ip & cp0_status[8 +: INT_MASK_WIDTH])) & mem_valid;
    assign sync_req = mem_valid & (mem_exc_code != EC_NONE);
    assign issue    = int_req | sync_req;
    // A delay-slot instruction restarts at its branch.
    assign epc      = mem_in_delay_slot ? (mem_pc - 32'd4) : mem_pc;

    // -------------------------------------------------------------------------
    // Request FSM
    // -------------------------------------------------------------------------
    logic [EXC_CODE_WIDTH-1:0] code_reg, code_next;
    logic [31:0]               epc_reg, epc_next;
    logic [31:0]               badvaddr_reg, badvaddr_next;
    logic                      flush_reg, flush_next;
    logic [INT_MASK_WIDTH-1:0] exc_ip_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            code_reg     <= EC_NONE;
            epc_reg      <= 32'd0;
            badvaddr_reg <= 32'd0;
            flush_reg    <= 1'b0;
            exc_ip_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            code_reg     <= code_next;
            epc_reg      <= epc_next;
            badvaddr_reg <= badvaddr_next;
            flush_reg    <= flush_next;
            exc_ip_reg   <= ip;
        end
    end

    always_comb begin
        state_next    = state_reg;
        code_next     = EC_NONE;
        epc_next      = epc_reg;
        badvaddr_next = badvaddr_reg;
        case (state_reg)
            S_IDLE: begin
                if (issue) begin
                    code_next     = int_req ? EC_INT : mem_exc_code;
                    epc_next      = epc;
                    badvaddr_next = int_req ? 32'd0 : mem_badvaddr;
                    state_next    = S_FIRED;
                end
            end
            S_FIRED: begin
                // CP0 may answer in the very cycle the request is visible.
                state_next = exc_jmp_flag ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (exc_jmp_flag) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Flush covers every cycle spent outside IDLE.
        flush_next = (state_next != S_IDLE);
    end

    assign exc_ip        = exc_ip_reg;
    assign exc_code      = code_reg;
    assign exc_epc       = epc_reg;
    assign exc_badvaddr  = badvaddr_reg;
    assign flush         = flush_reg;
    assign timer_pending = timer_pending_int;

endmodule

// File: tb/tb_exc_arbiter.sv
// -----------------------------------------------------------------------------
// tb_exc_arbiter
//
// Directed bench for exc_arbiter. A behavioural model tracks what CP0 must
// see each cycle (pending vector from a sample history, a single "held off"
// flag for the request handshake, the timer latch) and is compared with the
// DUT every cycle. Directed steps add literal expectations computed by hand.
// Timer steps follow the TIMER_IRQ_EN build option.
// -----------------------------------------------------------------------------
module tb_exc_arbiter;

    localparam int SYNC = 2;
    localparam logic [5:0] EC_NONE = 6'h20;
    localparam logic [5:0] EC_ERET = 6'h21;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hw_irq;
    logic [31:0] cp0_status, cp0_cause, cp0_count, cp0_compare;
    logic        compare_write;
    logic        mem_valid;
    logic [5:0]  mem_exc_code;
    logic [31:0] mem_pc;
    logic        mem_in_delay_slot;
    logic [31:0] mem_badvaddr;
    logic        exc_jmp_flag;
    logic [7:0]  exc_ip;
    logic [5:0]  exc_code;
    logic [31:0] exc_epc, exc_badvaddr;
    logic        flush, timer_pending;

    int tests = 0;
    int fails = 0;

    exc_arbiter #(
        .NR_HW_IRQ(6), .SYNC_STAGES(SYNC), .EXC_CODE_WIDTH(6),
        .INT_MASK_WIDTH(8), .EC_NONE(EC_NONE), .EC_ERET(EC_ERET)
    ) dut (
        .clk(clk), .rst(rst), .hw_irq(hw_irq),
        .cp0_status(cp0_status), .cp0_cause(cp0_cause),
        .cp0_count(cp0_count), .cp0_compare(cp0_compare),
        .compare_write(compare_write), .mem_valid(mem_valid),
        .mem_exc_code(mem_exc_code), .mem_pc(mem_pc),
        .mem_in_delay_slot(mem_in_delay_slot), .mem_badvaddr(mem_badvaddr),
        .exc_jmp_flag(exc_jmp_flag), .exc_ip(exc_ip), .exc_code(exc_code),
        .exc_epc(exc_epc), .exc_badvaddr(exc_badvaddr), .flush(flush),
        .timer_pending(timer_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    logic [5:0]  hist [SYNC];     // hw_irq samples, [0] newest
    bit          held;            // a request is outstanding until CP0 jumps
    bit          m_tp;
    bit          m_flush;
    bit          m_int;
    logic [7:0]  m_ip, m_ipv;
    logic [5:0]  m_code;
    logic [31:0] m_epc, m_bad;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < SYNC; i++) hist[i] = '0;
            held = 0; m_tp = 0; m_flush = 0;
            m_ip = '0; m_code = EC_NONE; m_epc = '0; m_bad = '0;
        end else begin
            m_ipv = {hist[SYNC-1], cp0_cause[9:8]};
            m_ipv[7] = m_ipv[7] | m_tp;
            m_int = cp0_status[0] && !cp0_status[1] &&
                    ((m_ipv & cp0_status[15:8]) != 8'h00) && mem_valid;
            m_ip = m_ipv;
            m_code = EC_NONE;
            if (held) begin
                if (exc_jmp_flag) held = 0;
            end else if (m_int) begin
                m_code = 6'd0;
                m_epc  = mem_in_delay_slot ? mem_pc - 32'd4 : mem_pc;
                m_bad  = 32'd0;
                held   = 1;
            end else if (mem_valid && mem_exc_code != EC_NONE) begin
                m_code = mem_exc_code;
                m_epc  = mem_in_delay_slot ? mem_pc - 32'd4 : mem_pc;
                m_bad  = mem_badvaddr;
                held   = 1;
            end
            m_flush = held;
`ifdef TIMER_IRQ_EN
            if (compare_write) m_tp = 0;
            else if (cp0_count == cp0_compare && cp0_compare != 0) m_tp = 1;
`endif
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = hw_irq;
        end
        #2;
        chk("model_exc_code", {26'd0, exc_code}, {26'd0, m_code});
        chk("model_exc_ip", {24'd0, exc_ip}, {24'd0, m_ip});
        chk("model_flush", {31'd0, flush}, {31'd0, m_flush});
        chk("model_timer_pending", {31'd0, timer_pending}, {31'd0, m_tp});
        if (m_code != EC_NONE) begin
            chk("model_exc_epc", exc_epc, m_epc);
            chk("model_exc_badvaddr", exc_badvaddr, m_bad);
            $display("[TB] t=%0t issue code=%02h epc=%08h badvaddr=%08h ip=%02h",
                     $time, exc_code, exc_epc, exc_badvaddr, exc_ip);
        end
    end

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mem(input bit v, input logic [5:0] code,
                           input logic [31:0] pc, input bit ds,
                           input logic [31:0] bad);
        mem_valid = v; mem_exc_code = code; mem_pc = pc;
        mem_in_delay_slot = ds; mem_badvaddr = bad;
    endtask

    initial begin
        rst = 1'b0; hw_irq = 6'h3F;
        cp0_status = 0; cp0_cause = 0; cp0_count = 0; cp0_compare = 0;
        compare_write = 0; exc_jmp_flag = 0;
        set_mem(0, EC_NONE, 0, 0, 0);

        // Reset with all lines high
        tick(); tick();
        chk("reset_code", {26'd0, exc_code}, {26'd0, EC_NONE});
        chk("reset_flush", {31'd0, flush}, 32'd0);
        chk("reset_ip", {24'd0, exc_ip}, 32'd0);
        rst = 1'b1;
        tick(); tick();
        chk("sync_ip_early", {24'd0, exc_ip}, 32'd0);
        tick();
        chk("sync_ip_ready", {24'd0, exc_ip}, 32'h0000_00FC);
        hw_irq = 6'h00;
        tick(); tick(); tick();

        // Syscall
        set_mem(1, 6'd8, 32'h8000_0100, 0, 32'h0000_1234);
        tick();
        chk("sys_code", {26'd0, exc_code}, 32'd8);
        chk("sys_epc", exc_epc, 32'h8000_0100);
        chk("sys_bad", exc_badvaddr, 32'h0000_1234);
        chk("sys_flush", {31'd0, flush}, 32'd1);
        set_mem(0, EC_NONE, 0, 0, 0);
        tick();
        chk("sys_code_after", {26'd0, exc_code}, {26'd0, EC_NONE});
        chk("sys_flush_wait", {31'd0, flush}, 32'd1);
        tick();
        exc_jmp_flag = 1;
        tick();
        exc_jmp_flag = 0;
        chk("sys_flush_done", {31'd0, flush}, 32'd0);

        // Holdoff: second syscall presented during WAIT
        set_mem(1, 6'd8, 32'h8000_0300, 0, 0);
        tick();
        chk("hold_first_epc", exc_epc, 32'h8000_0300);
        set_mem(1, 6'd8, 32'h8000_0400, 0, 0);
        tick();
        chk("hold_ignored1", {26'd0, exc_code}, {26'd0, EC_NONE});
        tick();
        chk("hold_ignored2", {26'd0, exc_code}, {26'd0, EC_NONE});
        exc_jmp_flag = 1;
        tick();
        exc_jmp_flag = 0;
        chk("hold_jmp_cycle", {26'd0, exc_code}, {26'd0, EC_NONE});
        chk("hold_jmp_flush", {31'd0, flush}, 32'd0);
        tick();
        chk("hold_second_code", {26'd0, exc_code}, 32'd8);
        chk("hold_second_epc", exc_epc, 32'h8000_0400);
        tick();
        chk("hold_wait_flush", {31'd0, flush}, 32'd1);
        rst = 1'b0;
        tick();
        chk("rst_wait_flush", {31'd0, flush}, 32'd0);
        chk("rst_wait_code", {26'd0, exc_code}, {26'd0, EC_NONE});
        rst = 1'b1;
        set_mem(0, EC_NONE, 0, 0, 0);
        tick();

        // Delay-slot interrupt beats a pending mem exception
        cp0_status = 32'h0000_0401; hw_irq = 6'h01;
        tick(); tick();
        set_mem(1, 6'd12, 32'h8000_0204, 1, 32'hBAD0_0004);
        tick();
        chk("int_code", {26'd0, exc_code}, 32'd0);
        chk("int_epc", exc_epc, 32'h8000_0200);
        chk("int_bad", exc_badvaddr, 32'd0);
        chk("int_ip", {24'd0, exc_ip}, 32'h0000_0004);
        mem_valid = 0; exc_jmp_flag = 1;
        tick();
        exc_jmp_flag = 0;
        chk("fired_to_idle_flush", {31'd0, flush}, 32'd0);

        // EXL masks the interrupt but not the exception
        cp0_status = 32'h0000_0403; mem_valid = 1;
        tick();
        chk("exl_code", {26'd0, exc_code}, 32'd12);
        chk("exl_bad", exc_badvaddr, 32'hBAD0_0004);
        mem_valid = 0; exc_jmp_flag = 1;
        tick();
        exc_jmp_flag = 0;

        // IM2 clear, no mem exception
        cp0_status = 32'h0000_0001;
        set_mem(1, EC_NONE, 32'h8000_0208, 0, 0);
        tick();
        chk("im_masked_code", {26'd0, exc_code}, {26'd0, EC_NONE});
        // Unmasked interrupt but mem_valid low
        cp0_status = 32'h0000_0401;
        set_mem(0, 6'd12, 32'h8000_0208, 0, 0);
        tick();
        chk("novalid_code", {26'd0, exc_code}, {26'd0, EC_NONE});
        chk("novalid_flush", {31'd0, flush}, 32'd0);

        // ERET passes through
        cp0_status = 0; hw_irq = 0;
        set_mem(1, EC_ERET, 32'h8000_0500, 0, 0);
        tick();
        chk("eret_code", {26'd0, exc_code}, {26'd0, EC_ERET});
        mem_valid = 0; exc_jmp_flag = 1;
        tick();
        exc_jmp_flag = 0;
        tick();

        // Software interrupt with EPC wrap
        cp0_cause = 32'h0000_0200; cp0_status = 32'h0000_0201;
        set_mem(1, EC_NONE, 32'h0000_0000, 1, 0);
        tick();
        chk("sw_code", {26'd0, exc_code}, 32'd0);
        chk("sw_epc_wrap", exc_epc, 32'hFFFF_FFFC);
        chk("sw_ip", {24'd0, exc_ip}, 32'h0000_0002);
        mem_valid = 0; exc_jmp_flag = 1; cp0_cause = 0;
        tick();
        exc_jmp_flag = 0;

        // Timer
        cp0_status = 32'h0000_8001; cp0_compare = 5; cp0_count = 4;
        tick();
        cp0_count = 5;
        tick();
`ifdef TIMER_IRQ_EN
        chk("timer_set", {31'd0, timer_pending}, 32'd1);
`else
        chk("timer_off", {31'd0, timer_pending}, 32'd0);
`endif
        cp0_count = 6;
        set_mem(1, EC_NONE, 32'h8000_0600, 0, 0);
        tick();
`ifdef TIMER_IRQ_EN
        chk("timer_int_code", {26'd0, exc_code}, 32'd0);
`else
        chk("timer_off_code", {26'd0, exc_code}, {26'd0, EC_NONE});
`endif
        mem_valid = 0; exc_jmp_flag = 1;
        tick();
        exc_jmp_flag = 0;
        compare_write = 1;
        tick();
        chk("timer_clear", {31'd0, timer_pending}, 32'd0);
        cp0_count = 5;
        tick();
        chk("timer_clear_wins", {31'd0, timer_pending}, 32'd0);
        compare_write = 0;
        tick();
        cp0_compare = 0; cp0_count = 0; compare_write = 1;
        tick();
        compare_write = 0;
        tick();
        chk("timer_zero_compare", {31'd0, timer_pending}, 32'd0);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
